// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch sequencer for the RISC core.
// It owns the program counter, issues word-addressed reads to InstrMem and
// buffers the returned words in a shift FIFO. The FIFO head drives decode
// over a valid/ready handshake. Branch/jump redirects and HALT are handled here.
// Read pipeline: issue (r_mem_en) -> memory data phase (r_cap_valid) -> FIFO push.
module instr_fetch_ctrl #(
    parameter logic [31:0] RESET_PC    = 32'd0,
    parameter int          FIFO_DEPTH  = 4,
    parameter logic [5:0]  HALT_OPCODE = 6'b111111
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        mem_en,
    output logic [31:0] mem_pc,
    input  logic [31:0] mem_instruction,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instruction,
    output logic [31:0] out_pc,
    output logic        halted,
    output logic [1:0]  state
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_HALT  = 2'd3;

    // Wide enough to hold FIFO occupancy plus two outstanding reads.
    localparam int CW = $clog2(FIFO_DEPTH + 3) + 1;

    logic [1:0]    r_state;
    logic [1:0]    w_state_nxt;
    logic [31:0]   r_fetch_pc;
    logic          r_mem_en;
    logic [31:0]   r_mem_pc;
    logic          r_cap_valid;
    logic [31:0]   r_cap_pc;
    logic [CW-1:0] r_count;
    logic          r_out_valid;
    logic          r_halted;
    logic [31:0]   r_fifo_instr [FIFO_DEPTH];
    logic [31:0]   r_fifo_pc    [FIFO_DEPTH];
    logic [31:0]   w_fifo_instr_nxt [FIFO_DEPTH];
    logic [31:0]   w_fifo_pc_nxt    [FIFO_DEPTH];

    logic          w_pop;
    logic          w_redirect;
    logic          w_push;
    logic          w_halt_cap;
    logic [CW-1:0] w_occ;
    logic          w_credit;
    logic          w_issue;
    logic [CW-1:0] w_count_nxt;
    logic [CW-1:0] w_wr_idx;

    assign mem_en          = r_mem_en;
    assign mem_pc          = r_mem_pc;
    assign out_valid       = r_out_valid;
    assign out_instruction = r_fifo_instr[0];
    assign out_pc          = r_fifo_pc[0];
    assign halted          = r_halted;
    assign state           = r_state;

    // FSM state register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic; redirect outranks halt detection and drain completion.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (w_redirect) begin
                    w_state_nxt = ST_RUN;
                end else if (w_halt_cap) begin
                    w_state_nxt = ST_DRAIN;
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (w_redirect) begin
                    w_state_nxt = ST_RUN;
                end else if (w_pop && (r_count == CW'(1))) begin
                    w_state_nxt = ST_HALT;
                end else begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_HALT: begin
                if (w_redirect) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_state_nxt = ST_HALT;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // FSM output decode: pop/push/halt detection and the credit-based issue decision.
    always_comb begin
        w_pop      = r_out_valid & out_ready;
        w_redirect = redirect & (r_state != ST_IDLE);
        w_push     = r_cap_valid & (r_state == ST_RUN) & ~w_redirect;
        w_halt_cap = w_push & (mem_instruction[31:26] == HALT_OPCODE);
        // Everything already committed to FIFO space: stored entries plus reads in flight.
        w_occ      = r_count + CW'(r_mem_en) + CW'(r_cap_valid);
        w_credit   = (w_occ < (CW'(FIFO_DEPTH) + CW'(w_pop)));
        w_issue    = (r_state == ST_RUN) & ~w_redirect & ~w_halt_cap & w_credit;
        if (w_redirect) begin
            w_count_nxt = {CW{1'b0}};
        end else begin
            w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);
        end
        w_wr_idx = r_count - CW'(w_pop);
    end

    // Shift-FIFO next contents: a pop shifts live entries toward the head; a push lands after the survivors.
    always_comb begin
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            w_fifo_instr_nxt[i] = r_fifo_instr[i];
            w_fifo_pc_nxt[i]    = r_fifo_pc[i];
        end
        for (int i = 0; i < FIFO_DEPTH - 1; i++) begin
            if (w_pop && (CW'(i + 1) < r_count)) begin
                w_fifo_instr_nxt[i] = r_fifo_instr[i + 1];
                w_fifo_pc_nxt[i]    = r_fifo_pc[i + 1];
            end else begin
                w_fifo_instr_nxt[i] = r_fifo_instr[i];
                w_fifo_pc_nxt[i]    = r_fifo_pc[i];
            end
        end
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (w_push && (w_wr_idx == CW'(i))) begin
                w_fifo_instr_nxt[i] = mem_instruction;
                w_fifo_pc_nxt[i]    = r_cap_pc;
            end else begin
                w_fifo_instr_nxt[i] = w_fifo_instr_nxt[i];
                w_fifo_pc_nxt[i]    = w_fifo_pc_nxt[i];
            end
        end
    end

    // Fetch datapath: PC, read issue, in-flight tracking, FIFO storage and status flags.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_fetch_pc  <= RESET_PC;
            r_mem_en    <= 1'b0;
            r_mem_pc    <= RESET_PC;
            r_cap_valid <= 1'b0;
            r_cap_pc    <= 32'd0;
            r_count     <= {CW{1'b0}};
            r_out_valid <= 1'b0;
            r_halted    <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_fifo_instr[i] <= 32'd0;
                r_fifo_pc[i]    <= 32'd0;
            end
        end else begin
            r_mem_en <= w_issue;
            if (w_issue) begin
                r_mem_pc <= r_fetch_pc;
            end
            if (w_redirect) begin
                r_fetch_pc <= redirect_pc;
            end else if ((r_state == ST_IDLE) && start) begin
                r_fetch_pc <= RESET_PC;
            end else if (w_issue) begin
                r_fetch_pc <= r_fetch_pc + 32'd1;
            end
            // A read issued before a redirect or a captured HALT is squashed here.
            r_cap_valid <= r_mem_en & ~w_redirect & ~w_halt_cap;
            r_cap_pc    <= r_mem_pc;
            r_count     <= w_count_nxt;
            r_out_valid <= (w_count_nxt != {CW{1'b0}});
            r_halted    <= (w_state_nxt == ST_HALT);
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_fifo_instr[i] <= w_fifo_instr_nxt[i];
                r_fifo_pc[i]    <= w_fifo_pc_nxt[i];
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Directed bench for instr_fetch_ctrl: a per-cycle vector table plus a short
// hand-written sequence. InstrMem is modelled as a registered read whose word
// is a function of the address, with an optional HALT word at address 3.
module tb_instr_fetch_ctrl;

    logic        clk;
    logic        reset;
    logic        start;
    logic        mem_en;
    logic [31:0] mem_pc;
    logic [31:0] mem_instruction;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instruction;
    logic [31:0] out_pc;
    logic        halted;
    logic [1:0]  state;

    logic        halt_mode;
    int          n_checks;
    int          n_fail;

    typedef struct {
        logic        rst_n;
        logic        start;
        logic        ready;
        logic        redir;
        logic [31:0] rpc;
        logic        hm;
        logic        ev;
        logic [31:0] epc;
        logic        men;
        logic [31:0] empc;
        logic [1:0]  est;
        logic        hlt;
        logic        zo;
    } vec_t;

    vec_t vecs[$];

    instr_fetch_ctrl dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .mem_en          (mem_en),
        .mem_pc          (mem_pc),
        .mem_instruction (mem_instruction),
        .redirect        (redirect),
        .redirect_pc     (redirect_pc),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_instruction (out_instruction),
        .out_pc          (out_pc),
        .halted          (halted),
        .state           (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a, input logic hm);
        if (hm && (a == 32'd3)) begin
            return 32'hFC000000;
        end
        return {6'b000010, a[25:0]};
    endfunction

    // InstrMem: data for the address presented at an edge appears after that edge.
    always @(posedge clk) begin
        mem_instruction <= mem_word(mem_pc, halt_mode);
    end

    function automatic vec_t mk(input int rst, input int st, input int rdy, input int rd,
                                input int rpc, input int hm, input int ev, input int epc,
                                input int men, input int empc, input int est, input int hl,
                                input int zo);
        vec_t v;
        v.rst_n = (rst != 0);
        v.start = (st != 0);
        v.ready = (rdy != 0);
        v.redir = (rd != 0);
        v.rpc   = 32'(rpc);
        v.hm    = (hm != 0);
        v.ev    = (ev != 0);
        v.epc   = 32'(epc);
        v.men   = (men != 0);
        v.empc  = 32'(empc);
        v.est   = 2'(est);
        v.hlt   = (hl != 0);
        v.zo    = (zo != 0);
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @vec %0d: got %h, expected %h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic st, input logic rdy, input logic rd,
                         input logic [31:0] rpc, input logic hm);
        reset       = rst;
        start       = st;
        out_ready   = rdy;
        redirect    = rd;
        redirect_pc = rpc;
        halt_mode   = hm;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        drive(1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 1'b0);

        // Sequential fetch, then redirect to 0x20 while out_pc=2 is being accepted.
        vecs.push_back(mk(0,0,1,0,0,0, 0,0,0,0,0,0,1));
        vecs.push_back(mk(0,0,1,0,0,0, 0,0,0,0,0,0,1));
        vecs.push_back(mk(1,1,1,0,0,0, 0,0,0,0,1,0,0));
        vecs.push_back(mk(1,0,1,0,0,0, 0,0,1,0,1,0,0));
        vecs.push_back(mk(1,0,1,0,0,0, 0,0,1,1,1,0,0));
        vecs.push_back(mk(1,0,1,0,0,0, 1,0,1,2,1,0,0));
        vecs.push_back(mk(1,0,1,0,0,0, 1,1,1,3,1,0,0));
        vecs.push_back(mk(1,0,1,0,0,0, 1,2,1,4,1,0,0));
        vecs.push_back(mk(1,0,1,1,32'h20,0, 0,0,0,0,1,0,0));
        vecs.push_back(mk(1,0,1,0,0,0, 0,0,1,32'h20,1,0,0));
        vecs.push_back(mk(1,0,1,0,0,0, 0,0,1,32'h21,1,0,0));
        vecs.push_back(mk(1,0,1,0,0,0, 1,32'h20,1,32'h22,1,0,0));
        vecs.push_back(mk(1,0,1,0,0,0, 1,32'h21,1,32'h23,1,0,0));
        // Backpressure: FIFO fills to 4, issue stops, stream resumes without gap.
        vecs.push_back(mk(0,0,0,0,0,0, 0,0,0,0,0,0,1));
        vecs.push_back(mk(1,1,0,0,0,0, 0,0,0,0,1,0,0));
        vecs.push_back(mk(1,0,0,0,0,0, 0,0,1,0,1,0,0));
        vecs.push_back(mk(1,0,0,0,0,0, 0,0,1,1,1,0,0));
        vecs.push_back(mk(1,0,0,0,0,0, 1,0,1,2,1,0,0));
        vecs.push_back(mk(1,0,0,0,0,0, 1,0,1,3,1,0,0));
        for (int i = 0; i < 9; i++) begin
            vecs.push_back(mk(1,0,0,0,0,0, 1,0,0,0,1,0,0));
        end
        vecs.push_back(mk(1,0,1,0,0,0, 1,1,1,4,1,0,0));
        vecs.push_back(mk(1,0,1,0,0,0, 1,2,1,5,1,0,0));
        vecs.push_back(mk(1,0,1,0,0,0, 1,3,1,6,1,0,0));
        vecs.push_back(mk(1,0,1,0,0,0, 1,4,1,7,1,0,0));
        vecs.push_back(mk(1,0,1,0,0,0, 1,5,1,8,1,0,0));
        // Halt at address 3, drain, start ignored in HALT, redirect to 0 resumes.
        vecs.push_back(mk(0,0,1,0,0,1, 0,0,0,0,0,0,1));
        vecs.push_back(mk(1,1,1,0,0,1, 0,0,0,0,1,0,0));
        vecs.push_back(mk(1,0,1,0,0,1, 0,0,1,0,1,0,0));
        vecs.push_back(mk(1,0,1,0,0,1, 0,0,1,1,1,0,0));
        vecs.push_back(mk(1,0,1,0,0,1, 1,0,1,2,1,0,0));
        vecs.push_back(mk(1,0,1,0,0,1, 1,1,1,3,1,0,0));
        vecs.push_back(mk(1,0,1,0,0,1, 1,2,1,4,1,0,0));
        vecs.push_back(mk(1,0,1,0,0,1, 1,3,0,0,2,0,0));
        vecs.push_back(mk(1,0,1,0,0,1, 0,0,0,0,3,1,0));
        vecs.push_back(mk(1,1,1,0,0,1, 0,0,0,0,3,1,0));
        vecs.push_back(mk(1,0,1,0,0,1, 0,0,0,0,3,1,0));
        vecs.push_back(mk(1,0,1,1,0,1, 0,0,0,0,1,0,0));
        vecs.push_back(mk(1,0,1,0,0,1, 0,0,1,0,1,0,0));
        vecs.push_back(mk(1,0,1,0,0,1, 0,0,1,1,1,0,0));
        vecs.push_back(mk(1,0,1,0,0,1, 1,0,1,2,1,0,0));
        // Wrap-around past 32'hFFFFFFFF.
        vecs.push_back(mk(1,0,1,1,32'hFFFFFFFE,1, 0,0,0,0,1,0,0));
        vecs.push_back(mk(1,0,1,0,0,1, 0,0,1,32'hFFFFFFFE,1,0,0));
        vecs.push_back(mk(1,0,1,0,0,1, 0,0,1,32'hFFFFFFFF,1,0,0));
        vecs.push_back(mk(1,0,1,0,0,1, 1,32'hFFFFFFFE,1,0,1,0,0));
        vecs.push_back(mk(1,0,1,0,0,1, 1,32'hFFFFFFFF,1,1,1,0,0));
        vecs.push_back(mk(1,0,1,0,0,1, 1,0,1,2,1,0,0));
        vecs.push_back(mk(1,0,1,0,0,1, 1,1,1,3,1,0,0));
        // Reset mid-stream, nothing delivered until a new start.
        vecs.push_back(mk(0,0,1,0,0,1, 0,0,0,0,0,0,1));
        vecs.push_back(mk(1,0,1,0,0,1, 0,0,0,0,0,0,0));
        vecs.push_back(mk(1,0,1,0,0,1, 0,0,0,0,0,0,0));
        vecs.push_back(mk(1,1,1,0,0,1, 0,0,0,0,1,0,0));
        vecs.push_back(mk(1,0,1,0,0,1, 0,0,1,0,1,0,0));
        vecs.push_back(mk(1,0,1,0,0,1, 0,0,1,1,1,0,0));
        vecs.push_back(mk(1,0,1,0,0,1, 1,0,1,2,1,0,0));

        foreach (vecs[i]) begin
            drive(vecs[i].rst_n, vecs[i].start, vecs[i].ready, vecs[i].redir, vecs[i].rpc, vecs[i].hm);
            @(posedge clk);
            #1;
            chk("out_valid", i, 32'(out_valid), 32'(vecs[i].ev));
            chk("mem_en", i, 32'(mem_en), 32'(vecs[i].men));
            chk("state", i, 32'(state), 32'(vecs[i].est));
            chk("halted", i, 32'(halted), 32'(vecs[i].hlt));
            if (vecs[i].ev) begin
                chk("out_pc", i, out_pc, vecs[i].epc);
                chk("out_instruction", i, out_instruction, mem_word(vecs[i].epc, vecs[i].hm));
            end
            if (vecs[i].men) begin
                chk("mem_pc", i, mem_pc, vecs[i].empc);
            end
            if (vecs[i].zo) begin
                chk("reset_out_pc", i, out_pc, 32'd0);
                chk("reset_out_instruction", i, out_instruction, 32'd0);
                chk("reset_mem_pc", i, mem_pc, 32'd0);
            end
        end

        // Hand-written: redirect is ignored in IDLE; start still fetches from RESET_PC.
        drive(1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            drive(1'b1, 1'b0, 1'b1, 1'b1, 32'h40, 1'b0);
            @(posedge clk);
            #1;
            chk("idle_redirect_state", 1000 + k, 32'(state), 32'd0);
            chk("idle_redirect_mem_en", 1000 + k, 32'(mem_en), 32'd0);
        end
        drive(1'b1, 1'b1, 1'b1, 1'b0, 32'd0, 1'b0);
        @(posedge clk);
        #1;
        chk("idle_start_state", 1002, 32'(state), 32'd1);
        drive(1'b1, 1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
        @(posedge clk);
        #1;
        chk("idle_first_mem_en", 1003, 32'(mem_en), 32'd1);
        chk("idle_first_mem_pc", 1003, mem_pc, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
